// File: rtl/irq_pending_latch_if.sv
// Signal bundle between the interrupt pending latch and its surroundings.
// The master side drives the request lines, the mask and the acknowledge from the encoder.
// The slave side (the latch) returns the masked pending vector, irq_out and overrun.
// Ports: irq_in[8], mask[8], ack, ack_id[3], clr_overrun drive the latch.
//        pend_masked[8], irq_out, overrun[8] are returned by the latch.
interface irq_pending_latch_if;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_id;
  logic       clr_overrun;
  logic [7:0] pend_masked;
  logic       irq_out;
  logic [7:0] overrun;

  modport master (
    output irq_in, mask, ack, ack_id, clr_overrun,
    input  pend_masked, irq_out, overrun
  );

  modport slave (
    input  irq_in, mask, ack, ack_id, clr_overrun,
    output pend_masked, irq_out, overrun
  );
endinterface

// File: rtl/irq_pending_latch.sv
// Purpose: synchronise 8 async request lines, latch events into a pending vector
//   that feeds the 8-to-3 encoder, and pace irq_out around each acknowledge.
// Latency: irq_in rise to pend is SYNC_STAGES+1 edges; irq_out follows one edge later.
// Backpressure: none; pending bits hold until acked, repeat events flag overrun.
// Ports: clk, rst_n (async active-low), bus (slave modport): irq_in, mask, ack,
//   ack_id, clr_overrun in; pend_masked, irq_out, overrun out.
module irq_pending_latch #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  irq_pending_latch_if.slave       bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0] s;
  logic [7:0] s_d;
  logic [7:0] ev;
  logic [7:0] ack_hit;
  logic [7:0] pend;
  logic [7:0] overrun_q;
  logic       pend_any;
  state_t     state;
  state_t     state_nxt;

  // Synchroniser: stage 0 samples the raw lines, last stage is the clean copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.irq_in};
      s_d    <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign ev = s & ~s_d;
    end else begin : g_level
      assign ev = s;
    end
  endgenerate

  assign ack_hit = bus.ack ? (8'b1 << bus.ack_id) : 8'b0;

  // An event outranks a same-cycle ack on the same bit, so a fresh request is
  // never lost; that collision is also not an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      overrun_q <= '0;
    end else begin
      pend      <= ev | (pend & ~ack_hit);
      overrun_q <= (overrun_q & ~{8{bus.clr_overrun}}) | (ev & pend & ~ack_hit);
    end
  end

  assign bus.pend_masked = pend & bus.mask;
  assign bus.overrun     = overrun_q;
  assign pend_any        = |bus.pend_masked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLDOFF gives the encoder a cycle to see the cleared pend bit before the
  // request can be raised again.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pend_any) state_nxt = ST_ASSERT;
      ST_ASSERT: begin
        if (bus.ack)        state_nxt = ST_HOLDOFF;
        else if (!pend_any) state_nxt = ST_IDLE;
      end
      ST_HOLDOFF: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // irq_out is decoded straight from the state flop, so it is glitch-free.
  assign bus.irq_out = (state == ST_ASSERT);

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  irq_pending_latch_if bus0 ();
  irq_pending_latch_if bus1 ();

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  irq_pending_latch #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_level (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.irq_in = 8'h00; bus0.mask = 8'hFF; bus0.ack = 1'b0;
    bus0.ack_id = 3'd0; bus0.clr_overrun = 1'b0;
    bus1.irq_in = 8'h00; bus1.mask = 8'hFF; bus1.ack = 1'b0;
    bus1.ack_id = 3'd0; bus1.clr_overrun = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.irq_in = 8'hFF; bus0.mask = 8'hFF; bus0.ack = 1'b0;
    bus0.ack_id = 3'd0; bus0.clr_overrun = 1'b0;
    bus1.irq_in = 8'h00; bus1.mask = 8'hFF; bus1.ack = 1'b0;
    bus1.ack_id = 3'd0; bus1.clr_overrun = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus0.pend_masked !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_pend cyc%0d: got %h want 00", i, bus0.pend_masked);
      end
      n_cmp++;
      if (bus0.irq_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_irq cyc%0d: got %b want 0", i, bus0.irq_out);
      end
      n_cmp++;
      if (bus0.overrun !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_ovr cyc%0d: got %h want 00", i, bus0.overrun);
      end
    end
    bus0.irq_in = 8'h00;
  endtask

  task automatic test_latency();
    do_reset();
    tick();                       // edge k
    bus0.irq_in = 8'h20;
    ticks(2);                     // after k+2
    n_cmp++;
    if (bus0.pend_masked !== 8'h00) begin
      n_fail++;
      $display("FAIL lat_k2_pend: got %h want 00", bus0.pend_masked);
    end
    tick();                       // after k+3
    n_cmp++;
    if (bus0.pend_masked !== 8'h20) begin
      n_fail++;
      $display("FAIL lat_k3_pend: got %h want 20", bus0.pend_masked);
    end
    n_cmp++;
    if (bus0.irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_k3_irq: got %b want 0", bus0.irq_out);
    end
    tick();                       // after k+4
    n_cmp++;
    if (bus0.irq_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_k4_irq: got %b want 1", bus0.irq_out);
    end
  endtask

  task automatic test_ack_holdoff();
    do_reset();
    bus0.irq_in = 8'h24;
    ticks(4);
    n_cmp++;
    if (bus0.pend_masked !== 8'h24 || bus0.irq_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_pre: got pend %h irq %b want 24 1", bus0.pend_masked, bus0.irq_out);
    end
    bus0.ack = 1'b1; bus0.ack_id = 3'd5;
    tick();
    bus0.ack = 1'b0;
    n_cmp++;
    if (bus0.pend_masked !== 8'h04) begin
      n_fail++;
      $display("FAIL ack_pend: got %h want 04", bus0.pend_masked);
    end
    n_cmp++;
    if (bus0.irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_holdoff_irq: got %b want 0", bus0.irq_out);
    end
    ticks(2);
    n_cmp++;
    if (bus0.irq_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_reassert_irq: got %b want 1", bus0.irq_out);
    end
    // Ack to a channel that is not pending changes nothing in pend.
    bus0.ack = 1'b1; bus0.ack_id = 3'd1;
    tick();
    bus0.ack = 1'b0;
    n_cmp++;
    if (bus0.pend_masked !== 8'h04) begin
      n_fail++;
      $display("FAIL ack_nonpend: got %h want 04", bus0.pend_masked);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus0.irq_in = 8'h08;
    ticks(4);
    bus0.irq_in = 8'h00;
    ticks(3);
    bus0.irq_in = 8'h08;          // second rising edge while pend[3]=1
    ticks(3);
    n_cmp++;
    if (bus0.overrun !== 8'h08) begin
      n_fail++;
      $display("FAIL ovr_set: got %h want 08", bus0.overrun);
    end
    bus0.clr_overrun = 1'b1;
    tick();
    bus0.clr_overrun = 1'b0;
    n_cmp++;
    if (bus0.overrun !== 8'h00) begin
      n_fail++;
      $display("FAIL ovr_clr: got %h want 00", bus0.overrun);
    end
    bus0.irq_in = 8'h00;
    ticks(3);
    tick();                       // edge k: new rise
    bus0.irq_in = 8'h08;
    ticks(2);
    bus0.ack = 1'b1; bus0.ack_id = 3'd3;   // lands on the event edge k+3
    tick();
    bus0.ack = 1'b0;
    n_cmp++;
    if (bus0.overrun !== 8'h00) begin
      n_fail++;
      $display("FAIL ovr_coincident: got %h want 00", bus0.overrun);
    end
    n_cmp++;
    if (bus0.pend_masked !== 8'h08) begin
      n_fail++;
      $display("FAIL ovr_coincident_pend: got %h want 08", bus0.pend_masked);
    end
  endtask

  task automatic test_mask();
    do_reset();
    bus0.mask = 8'hFE;
    bus0.irq_in = 8'h01;
    ticks(5);
    n_cmp++;
    if (bus0.pend_masked !== 8'h00 || bus0.irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_off: got pend %h irq %b want 00 0", bus0.pend_masked, bus0.irq_out);
    end
    bus0.mask = 8'hFF;
    #1;
    n_cmp++;
    if (bus0.pend_masked !== 8'h01) begin
      n_fail++;
      $display("FAIL mask_on_pend: got %h want 01", bus0.pend_masked);
    end
    ticks(2);
    n_cmp++;
    if (bus0.irq_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mask_on_irq: got %b want 1", bus0.irq_out);
    end
    // Masking off while asserted drops the request without an ack.
    bus0.mask = 8'h00;
    tick();
    n_cmp++;
    if (bus0.irq_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_drop_irq: got %b want 0", bus0.irq_out);
    end
  endtask

  task automatic test_level_mode();
    do_reset();
    bus1.irq_in = 8'h80;
    ticks(5);
    n_cmp++;
    if (bus1.pend_masked !== 8'h80) begin
      n_fail++;
      $display("FAIL lvl_pend: got %h want 80", bus1.pend_masked);
    end
    bus1.ack = 1'b1; bus1.ack_id = 3'd7;
    tick();
    bus1.ack = 1'b0;
    n_cmp++;
    if (bus1.pend_masked !== 8'h80) begin
      n_fail++;
      $display("FAIL lvl_reset_after_ack: got %h want 80", bus1.pend_masked);
    end
    tick();
    n_cmp++;
    if (bus1.overrun !== 8'h80) begin
      n_fail++;
      $display("FAIL lvl_overrun: got %h want 80", bus1.overrun);
    end
    bus1.irq_in = 8'h00;
    ticks(3);
    bus1.ack = 1'b1; bus1.ack_id = 3'd7;
    tick();
    bus1.ack = 1'b0;
    n_cmp++;
    if (bus1.pend_masked !== 8'h00) begin
      n_fail++;
      $display("FAIL lvl_released_clear: got %h want 00", bus1.pend_masked);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    test_reset();
    test_latency();
    test_ack_holdoff();
    test_overrun();
    test_mask();
    test_level_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
